dmem_arbiter: RTL and testbench

- Shares the single data memory (64 x 32-bit words, combinational read, write on posedge clk) between the CPU load/store port and a secondary DMA/loader port.
- CPU has priority. A starvation counter and a burst cap guarantee forward progress for both sides.
- Sits in top between processor, data_mem and the loader.
- Asserts cpu_stall so the CPU holds its PC while it is denied.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 64 x 32-bit data memory between the CPU
// load/store port and a secondary DMA/loader port.
//
// The CPU has priority. A DMA request denied for MAX_WAIT cycles pre-empts
// the CPU, and a DMA burst is cut after MAX_BURST beats so the CPU gets a
// turn. Grant is combinational from the registered state and counters plus
// the current requests; read data is passed straight through from memory.
//
// Optional feature (macro DMEM_ARB_PROT_EN): DMA writes below PROT_BASE are
// still granted, but they are dropped and the sticky dma_err flag is set.
// Without the macro there is no address check and dma_err stays 0.
//
// Ports:
//   clk, reset (async, active low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//   dma_req/dma_we/dma_last/dma_addr/dma_wdata -> dma_rdata, dma_gnt, dma_err
//   mem_we/mem_addr/mem_wdata -> data_mem, mem_rdata <- data_mem
//
// state | meaning
// S_CPU | CPU has priority; DMA wins when CPU idle or after MAX_WAIT denials
// S_DMA | DMA burst in progress; DMA keeps the memory while it requests
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter logic [31:0] PROT_BASE = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_last,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_gnt,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {S_CPU, S_DMA} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0] BEAT_END = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       err_q, err_nxt;
  logic       dma_win, cpu_own, dma_lo, prot_viol;

  assign dma_lo = (dma_addr < PROT_BASE);

`ifdef DMEM_ARB_PROT_EN
  assign prot_viol = dma_win & dma_we & dma_lo;
`else
  // Check compiled out; the AND with 0 keeps PROT_BASE referenced.
  assign prot_viol = dma_win & dma_we & dma_lo & 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_CPU;
      wait_cnt <= 4'd0;
      beat_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    dma_win   = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    beat_nxt  = beat_cnt;
    err_nxt   = err_q | prot_viol;

    // Outputs are held inactive while reset is asserted.
    if (reset) begin
      if (state == S_DMA) dma_win = dma_req;
      else                dma_win = dma_req && (!cpu_req || wait_cnt == WAIT_MAX);
    end

    if (dma_win) begin
      wait_nxt = 4'd0;
      if (dma_last || beat_cnt == BEAT_END) begin
        state_nxt = S_CPU;
        beat_nxt  = 4'd0;
      end else begin
        state_nxt = S_DMA;
        beat_nxt  = beat_cnt + 4'd1;
      end
    end else begin
      // In S_DMA a lost grant means dma_req dropped: burst is over.
      state_nxt = S_CPU;
      beat_nxt  = 4'd0;
      if (!dma_req)                wait_nxt = 4'd0;
      else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 4'd1;
    end
  end

  assign cpu_own   = reset && cpu_req && !dma_win;
  assign cpu_stall = reset && cpu_req && dma_win;
  assign dma_gnt   = dma_win;
  assign dma_err   = err_q;

  assign mem_addr  = dma_win ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_win ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_win ? (dma_we & ~prot_viol) : (cpu_own & cpu_we);

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int          MAX_WAIT  = 4;
  localparam int          MAX_BURST = 8;
  localparam logic [31:0] PROT_BASE = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_last = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_err, mem_we;

  logic [31:0] ram     [64];   // the data memory the arbiter drives
  logic [31:0] ref_ram [64];   // the model's idea of memory contents

  int n_total = 0;
  int n_pass  = 0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST), .PROT_BASE(PROT_BASE)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt), .dma_err(dma_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: how long DMA has been refused, how many beats of the
  // current burst were taken, whether a burst is under way, sticky error.
  int m_wait = 0, m_beats = 0;
  bit m_in_burst = 0, m_err = 0;

  always @(negedge clk) begin
    bit e_dma, e_cpu, e_we, viol;
    if (!reset) begin
      check("rst_gnt", dma_gnt, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_we", mem_we, 0);
      check("rst_err", dma_err, 0);
      m_wait = 0; m_beats = 0; m_in_burst = 0; m_err = 0;
    end else begin
      e_dma = dma_req && (m_in_burst || !cpu_req || m_wait >= MAX_WAIT);
      e_cpu = cpu_req && !e_dma;
      viol  = 0;
`ifdef DMEM_ARB_PROT_EN
      viol  = e_dma && dma_we && (dma_addr < PROT_BASE);
`endif
      e_we  = e_dma ? (dma_we && !viol) : (e_cpu && cpu_we);
      check("gnt", dma_gnt, e_dma);
      check("stall", cpu_stall, cpu_req && e_dma);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_dma ? dma_addr : cpu_addr);
      check("dma_err", dma_err, m_err);
      if (e_we) check("mem_wdata", mem_wdata, e_dma ? dma_wdata : cpu_wdata);
      if (e_cpu) check("cpu_rdata", cpu_rdata, ref_ram[cpu_addr[7:2]]);
      if (e_dma) check("dma_rdata", dma_rdata, ref_ram[dma_addr[7:2]]);
      if (e_we) ref_ram[e_dma ? dma_addr[7:2] : cpu_addr[7:2]] = e_dma ? dma_wdata : cpu_wdata;
      if (viol) m_err = 1;
      if (e_dma) begin
        m_beats++;
        m_wait = 0;
        if (dma_last || m_beats == MAX_BURST) begin m_in_burst = 0; m_beats = 0; end
        else m_in_burst = 1;
      end else begin
        m_in_burst = 0; m_beats = 0;
        m_wait = dma_req ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0; dma_last = 0;
  endtask

  initial begin
    logic [31:0] old, a;
    for (int i = 0; i < 64; i++) begin ram[i] = $urandom; ref_ram[i] = ram[i]; end
    #1 reset = 0;
    cpu_req = 1; dma_req = 1; dma_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      check("t1_rst_stall", cpu_stall, 0);
      check("t1_rst_gnt", dma_gnt, 0);
      check("t1_rst_we", mem_we, 0);
    end

    // Release; CPU store 0xDEADBEEF to 0x10.
    next_cycle();
    reset = 1; idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    #2 check("t1_st_stall", cpu_stall, 0);
    next_cycle(); idle();
    #2 check("t1_ram4", ram[4], 32'hDEAD_BEEF);

    // Simultaneous requests: DMA wins on the fifth cycle.
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h04;
    dma_req = 1; dma_we = 0; dma_addr = 32'h40; dma_last = 1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("t2_gnt", dma_gnt, (c == 4));
      check("t2_stall", cpu_stall, (c == 4));
      if (c == 4) check("t2_rdata", dma_rdata, ram[16]);
      next_cycle();
    end
    idle();

    // Three-beat DMA write burst with CPU idle.
    next_cycle();
    for (int b = 0; b < 3; b++) begin
      dma_req = 1; dma_we = 1; dma_addr = 32'h80 + 32'(4 * b);
      dma_wdata = 32'hA000_0000 + 32'(b); dma_last = (b == 2);
      #2 check("t3_gnt", dma_gnt, 1);
      next_cycle();
    end
    cpu_req = 1; dma_req = 1; dma_we = 0; dma_last = 0;
    #2 check("t3_back_cpu", dma_gnt, 0);
    for (int b = 0; b < 3; b++) check("t3_ram", ram[32 + b], 32'hA000_0000 + 32'(b));
    next_cycle(); idle();

    // Long burst against a requesting CPU: 8 beats, then 4 refusals.
    next_cycle();
    for (int i = 0; i < 13; i++) begin
      cpu_req = (i > 0); cpu_we = 0; cpu_addr = 32'h08;
      dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h100 + 32'(4 * i);
      #2;
      check("t4_gnt", dma_gnt, (i < 8) || (i == 12));
      check("t4_stall", cpu_stall, (i > 0) && ((i < 8) || (i == 12)));
      next_cycle();
    end
    idle();

    // Reset during beat 2 of a burst.
    next_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 32'hC0; dma_wdata = 32'h1111_2222;
    next_cycle();
    old = ram[49];
    reset = 0; dma_addr = 32'hC4; dma_wdata = 32'h3333_4444;
    #2 check("t5_gnt", dma_gnt, 0);
    check("t5_we", mem_we, 0);
    next_cycle();
    check("t5_nowrite", ram[49], old);
    check("t5_beat1", ram[48], 32'h1111_2222);
    reset = 1; idle();
    #2 check("t5_gnt_idle", dma_gnt, 0);
    next_cycle();
    cpu_req = 1; dma_req = 1; dma_we = 0;
    #2 check("t5_cpu_state", dma_gnt, 0);
    next_cycle(); idle();

    // Write below the protection base.
    next_cycle();
    old = ram[8];
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678; dma_last = 1;
    #2 check("t6_gnt", dma_gnt, 1);
    next_cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      #2;
`ifdef DMEM_ARB_PROT_EN
      check("t6_ram8", ram[8], old);
      check("t6_err", dma_err, 1);
`else
      check("t6_ram8", ram[8], 32'h1234_5678);
      check("t6_err", dma_err, 0);
`endif
      next_cycle();
    end

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      reset   = ($urandom_range(0, 199) != 0);
      cpu_req = ($urandom_range(0, 2) != 0);
      cpu_we  = $urandom_range(0, 1);
      a = $urandom; a[1:0] = 2'b00; cpu_addr = a;
      cpu_wdata = $urandom;
      dma_req = ($urandom_range(0, 3) != 0);
      dma_we  = $urandom_range(0, 1);
      dma_last = ($urandom_range(0, 5) == 0);
      a = $urandom; a[1:0] = 2'b00; dma_addr = a;
      dma_wdata = $urandom;
      next_cycle();
    end
    reset = 1; idle();
    next_cycle();
    #2;
    for (int i = 0; i < 64; i++) check("final_ram", ram[i], ref_ram[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
